// File: rtl/simple_dma_pkg.sv
// Shared definitions for the simple DMA controller: FSM state encoding,
// byte-enable patterns and address stepping constants.
package simple_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_DEV = 3'd1,
    ST_ACCESS   = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_ACK      = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [1:0]  WE_WORD   = 2'b11;
  localparam logic [1:0]  WE_NONE   = 2'b00;
  localparam logic [15:0] ADDR_STEP = 16'd2;
  // Byte addresses are word aligned: bit 0 of the start address is dropped.
  localparam logic [15:0] ADDR_MASK = 16'hFFFE;

endpackage

// File: rtl/simple_dma_watchdog.sv
// Access watchdog: counts cycles the controller spends in ACCESS without
// dma_ready and flags expiry on the TIMEOUT_CYCLES-th such cycle. The count
// returns to zero whenever the controller is outside ACCESS, so every new
// access starts from a clean count.
module simple_dma_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic stall,
  output logic expire
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_q, count_d;

  // Next count: advance while stalled in ACCESS, clear outside it.
  always_comb begin
    count_d = 16'd0;
    if (active) begin
      count_d = stall ? count_q + 16'd1 : count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = active && stall && (count_q == LAST_COUNT);

endmodule

// File: rtl/simple_dma_controller.sv
// Single-channel DMA engine between the simple_dma_device peripheral and the
// openMSP430 DMA memory port. Moves one 16-bit word per device handshake,
// returns read data with a one-cycle dma_ack, and signals completion or a bus
// error with one-cycle end/error pulses.
// Build option: define SIMPLE_DMA_TIMEOUT_EN to add an ACCESS watchdog that
// aborts with an error after TIMEOUT_CYCLES cycles without dma_ready.
module simple_dma_controller
  import simple_dma_pkg::*;
#(
  parameter logic PRIORITY       = 1'b0,
  parameter int   TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_rqst,
  input  logic        dma_rd_wr,
  input  logic [15:0] dma_start_address,
  input  logic [15:0] dma_num_words,
  input  logic        dev_ack,
  input  logic [15:0] dev_out,
  output logic        dma_ack,
  output logic [15:0] dev_in,
  output logic        dma_end_flag,
  output logic        dma_error_flag,
  output logic [14:0] dma_addr,
  output logic [15:0] dma_din,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic        dma_priority,
  input  logic [15:0] dma_dout,
  input  logic        dma_ready,
  input  logic        dma_resp
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dev_in_q, dev_in_d;
  logic        dir_q, dir_d;
  logic        ack_q, ack_d;
  logic        end_q, end_d;
  logic        err_q, err_d;
  logic        expire;

`ifdef SIMPLE_DMA_TIMEOUT_EN
  simple_dma_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .active (state_q == ST_ACCESS),
    .stall  (~dma_ready),
    .expire (expire)
  );
`else
  // Without the watchdog an access waits for dma_ready indefinitely; the
  // parameter stays in the interface so both builds instantiate identically.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: device handshake, memory access, completion.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dma_rqst) begin
          state_d = (dma_num_words == 16'd0) ? ST_DONE : ST_WAIT_DEV;
        end
      end
      ST_WAIT_DEV: begin
        if (!dma_rqst)    state_d = ST_IDLE;
        else if (dev_ack) state_d = ST_ACCESS;
      end
      // The request is deliberately ignored here: a started access completes.
      ST_ACCESS: begin
        if (dma_ready) begin
          if (dma_resp)   state_d = ST_DONE;
          else if (dir_q) state_d = ST_CAPTURE;
          else            state_d = ST_ACK;
        end else if (expire) begin
          state_d = ST_DONE;
        end
      end
      ST_CAPTURE: state_d = ST_ACK;
      ST_ACK: begin
        if (cnt_q == 16'd1) state_d = ST_DONE;
        else if (!dma_rqst) state_d = ST_IDLE;
        else                state_d = ST_WAIT_DEV;
      end
      ST_DONE: begin
        if (!dma_rqst) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: memory port driven only in ACCESS; next values of the
  // registered pulses. ACCESS reaches DONE only through an error.
  always_comb begin
    dma_en   = 1'b0;
    dma_addr = 15'd0;
    dma_din  = 16'd0;
    dma_we   = WE_NONE;
    if (state_q == ST_ACCESS) begin
      dma_en   = 1'b1;
      dma_addr = addr_q[15:1];
      dma_din  = wdata_q;
      dma_we   = dir_q ? WE_NONE : WE_WORD;
    end
    ack_d = (state_d == ST_ACK);
    end_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    err_d = (state_d == ST_DONE) && (state_q == ST_ACCESS);
  end

  // Datapath next-state: latch the request, capture data, step address/count.
  always_comb begin
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    wdata_d  = wdata_q;
    dev_in_d = dev_in_q;
    case (state_q)
      ST_IDLE: begin
        if (dma_rqst) begin
          addr_d = dma_start_address & ADDR_MASK;
          cnt_d  = dma_num_words;
          dir_d  = dma_rd_wr;
        end
      end
      ST_WAIT_DEV: begin
        if (dma_rqst && dev_ack && !dir_q) wdata_d = dev_out;
      end
      ST_CAPTURE: dev_in_d = dma_dout;
      ST_ACK: begin
        addr_d = addr_q + ADDR_STEP;
        cnt_d  = cnt_q - 16'd1;
      end
      default: ;
    endcase
  end

  // Datapath and registered-output registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: datapath registers are reset too; several feed outputs that must read 0 out of reset.
    if (reset) begin
      addr_q   <= 16'd0;
      cnt_q    <= 16'd0;
      dir_q    <= 1'b0;
      wdata_q  <= 16'd0;
      dev_in_q <= 16'd0;
      ack_q    <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      wdata_q  <= wdata_d;
      dev_in_q <= dev_in_d;
      ack_q    <= ack_d;
      end_q    <= end_d;
      err_q    <= err_d;
    end
  end

  assign dma_ack        = ack_q;
  assign dev_in         = dev_in_q;
  assign dma_end_flag   = end_q;
  assign dma_error_flag = err_q;
  assign dma_priority   = PRIORITY;

endmodule

// File: tb/tb_simple_dma_controller.sv
// Directed bench for simple_dma_controller. A negedge-driven device/memory
// model answers the DUT and logs accesses, acknowledges and flags; the main
// sequence compares those logs with hand-computed expectations.
module tb_simple_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        dma_rqst, dma_rd_wr;
  logic [15:0] dma_start_address, dma_num_words;
  logic        dev_ack;
  logic [15:0] dev_out;
  logic        dma_ack;
  logic [15:0] dev_in;
  logic        dma_end_flag, dma_error_flag;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic        dma_priority;
  logic [15:0] dma_dout;
  logic        dma_ready, dma_resp;

  // Model configuration, written only by the main sequence.
  int          mem_wait, err_idx, dev_gap;
  logic        dev_ack_en;
  logic [15:0] wr_vals [8];
  logic [15:0] rd_vals [8];

  // Model state and logs, written only by the negedge model.
  int          cyc, wait_cnt, gap_cnt, wr_idx, rd_idx, acc_idx;
  int          en_cnt, end_cnt, err_cnt, end_cyc, err_cyc, unstable;
  logic        rd_pending, prev_en, prev_ready;
  logic [15:0] rd_data, prev_din;
  logic [14:0] prev_addr;
  logic [1:0]  prev_we;
  logic [14:0] acc_addr [$];
  logic [15:0] acc_din [$];
  logic [1:0]  acc_we [$];
  logic [15:0] ack_data [$];
  int          ack_cyc [$];

  int n_cmp = 0;
  int n_bad = 0;

  simple_dma_controller #(
    .PRIORITY      (1'b0),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .dma_rqst         (dma_rqst),
    .dma_rd_wr        (dma_rd_wr),
    .dma_start_address(dma_start_address),
    .dma_num_words    (dma_num_words),
    .dev_ack          (dev_ack),
    .dev_out          (dev_out),
    .dma_ack          (dma_ack),
    .dev_in           (dev_in),
    .dma_end_flag     (dma_end_flag),
    .dma_error_flag   (dma_error_flag),
    .dma_addr         (dma_addr),
    .dma_din          (dma_din),
    .dma_en           (dma_en),
    .dma_we           (dma_we),
    .dma_priority     (dma_priority),
    .dma_dout         (dma_dout),
    .dma_ready        (dma_ready),
    .dma_resp         (dma_resp)
  );

  always #5 clk = ~clk;

  // Device and memory model plus monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      wait_cnt = 0; gap_cnt = 0; wr_idx = 0; rd_idx = 0; acc_idx = 0;
      en_cnt = 0; end_cnt = 0; err_cnt = 0; end_cyc = -1; err_cyc = -2; unstable = 0;
      rd_pending = 1'b0; rd_data = 16'h0; prev_en = 1'b0; prev_ready = 1'b0;
      prev_addr = 15'h0; prev_din = 16'h0; prev_we = 2'b00;
      acc_addr.delete(); acc_din.delete(); acc_we.delete();
      ack_data.delete(); ack_cyc.delete();
      dev_ack = 1'b0; dev_out = 16'h0;
      dma_ready = 1'b0; dma_resp = 1'b0; dma_dout = 16'h0;
    end else begin
      if (dma_ack) begin
        ack_data.push_back(dev_in);
        ack_cyc.push_back(cyc);
        wr_idx  = wr_idx + 1;
        gap_cnt = dev_gap;
      end
      if (dma_end_flag) begin end_cnt = end_cnt + 1; end_cyc = cyc; end
      if (dma_error_flag) begin err_cnt = err_cnt + 1; err_cyc = cyc; end
      if (dma_en) begin
        en_cnt = en_cnt + 1;
        if (prev_en && !prev_ready &&
            (dma_addr !== prev_addr || dma_din !== prev_din || dma_we !== prev_we))
          unstable = unstable + 1;
      end
      prev_en = dma_en; prev_addr = dma_addr; prev_din = dma_din; prev_we = dma_we;

      dev_out = wr_vals[wr_idx[2:0]];
      dev_ack = dev_ack_en && (gap_cnt == 0);
      if (gap_cnt > 0) gap_cnt = gap_cnt - 1;

      dma_dout   = rd_pending ? rd_data : 16'hDEAD;
      rd_pending = 1'b0;
      dma_ready  = 1'b0;
      dma_resp   = 1'b0;
      if (dma_en) begin
        if (wait_cnt >= mem_wait) begin
          dma_ready = 1'b1;
          wait_cnt  = 0;
          acc_idx   = acc_idx + 1;
          acc_addr.push_back(dma_addr);
          acc_din.push_back(dma_din);
          acc_we.push_back(dma_we);
          dma_resp = (acc_idx == err_idx);
          if (dma_we == 2'b00) begin
            rd_pending = 1'b1;
            rd_data    = rd_vals[rd_idx[2:0]];
            rd_idx     = rd_idx + 1;
          end
        end else begin
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        wait_cnt = 0;
      end
      prev_ready = dma_ready;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1);
    reset = 1'b1; dma_rqst = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic start_xfer(input logic rd, input logic [15:0] addr, input logic [15:0] n);
    step(1);
    dma_rd_wr = rd; dma_start_address = addr; dma_num_words = n; dma_rqst = 1'b1;
  endtask

  // Bounded wait for the end pulse; an expired budget is a failed comparison.
  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (end_cnt == 0 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(end_cnt != 0), 32'd1);
  endtask

  task automatic drop_rqst();
    step(3);
    dma_rqst = 1'b0;
    step(3);
  endtask

  function automatic logic [31:0] q_addr(input int i);
    return (i < acc_addr.size()) ? 32'(acc_addr[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] q_din(input int i);
    return (i < acc_din.size()) ? 32'(acc_din[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] q_we(input int i);
    return (i < acc_we.size()) ? 32'(acc_we[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] q_ack(input int i);
    return (i < ack_data.size()) ? 32'(ack_data[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] ack_gap();
    return (ack_cyc.size() >= 2) ? 32'(ack_cyc[1] - ack_cyc[0]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int c0;
    int n;
    logic [14:0] exp_addr [3];
    logic [15:0] exp_data [3];

    reset = 1'b1; dma_rqst = 1'b0; dma_rd_wr = 1'b0;
    dma_start_address = 16'h0; dma_num_words = 16'h0;
    mem_wait = 0; err_idx = 0; dev_gap = 0; dev_ack_en = 1'b0;
    for (int i = 0; i < 8; i++) begin wr_vals[i] = 16'h0; rd_vals[i] = 16'h0; end
    step(3);

    // Reset state.
    check("rst_en", 32'(dma_en), 32'd0);
    check("rst_ack", 32'(dma_ack), 32'd0);
    check("rst_end", 32'(dma_end_flag), 32'd0);
    check("rst_err", 32'(dma_error_flag), 32'd0);
    check("rst_dev_in", 32'(dev_in), 32'd0);
    check("rst_addr", 32'(dma_addr), 32'd0);
    check("rst_we", 32'(dma_we), 32'd0);
    check("rst_prio", 32'(dma_priority), 32'd0);
    reset = 1'b0;

    // Write 3 words at 0x0200, zero-wait memory.
    do_reset();
    wr_vals[0] = 16'h00A1; wr_vals[1] = 16'h00B2; wr_vals[2] = 16'h00C3;
    dev_ack_en = 1'b1; mem_wait = 0; dev_gap = 0; err_idx = 0;
    start_xfer(1'b0, 16'h0200, 16'd3);
    wait_end("wr_end_seen", 40);
    drop_rqst();
    exp_addr[0] = 15'h0100; exp_addr[1] = 15'h0101; exp_addr[2] = 15'h0102;
    exp_data[0] = 16'h00A1; exp_data[1] = 16'h00B2; exp_data[2] = 16'h00C3;
    check("wr_n_acc", 32'(acc_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_addr%0d", i), q_addr(i), 32'(exp_addr[i]));
      check($sformatf("wr_din%0d", i), q_din(i), 32'(exp_data[i]));
      check($sformatf("wr_we%0d", i), q_we(i), 32'h3);
    end
    check("wr_n_ack", 32'(ack_data.size()), 32'd3);
    check("wr_cycles_per_word", ack_gap(), 32'd3);
    check("wr_end_cnt", 32'(end_cnt), 32'd1);
    check("wr_err_cnt", 32'(err_cnt), 32'd0);

    // Read 2 words from 0x0301 (bit 0 dropped).
    do_reset();
    rd_vals[0] = 16'h1234; rd_vals[1] = 16'h5678;
    dev_ack_en = 1'b1;
    start_xfer(1'b1, 16'h0301, 16'd2);
    wait_end("rd_end_seen", 40);
    drop_rqst();
    check("rd_n_acc", 32'(acc_addr.size()), 32'd2);
    check("rd_addr0", q_addr(0), 32'h0180);
    check("rd_addr1", q_addr(1), 32'h0181);
    check("rd_we0", q_we(0), 32'h0);
    check("rd_data0", q_ack(0), 32'h1234);
    check("rd_data1", q_ack(1), 32'h5678);
    check("rd_cycles_per_word", ack_gap(), 32'd4);
    check("rd_end_cnt", 32'(end_cnt), 32'd1);

    // Non-atomic write: device gap of 5 cycles, memory waits 2 cycles.
    do_reset();
    wr_vals[0] = 16'h1111; wr_vals[1] = 16'h2222;
    dev_gap = 5; mem_wait = 2;
    start_xfer(1'b0, 16'h0010, 16'd2);
    wait_end("na_end_seen", 60);
    drop_rqst();
    check("na_en_cycles", 32'(en_cnt), 32'd6);
    check("na_stable", 32'(unstable), 32'd0);
    check("na_addr1", q_addr(1), 32'h0009);
    check("na_din1", q_din(1), 32'h2222);
    check("na_n_ack", 32'(ack_data.size()), 32'd2);
    dev_gap = 0; mem_wait = 0;

    // Zero words: end pulse in the cycle after the request, no access.
    do_reset();
    start_xfer(1'b0, 16'h0040, 16'd0);
    c0 = cyc;
    wait_end("zero_end_seen", 10);
    drop_rqst();
    check("zero_end_cycle", 32'(end_cyc - c0), 32'd2);
    check("zero_en_cycles", 32'(en_cnt), 32'd0);
    check("zero_end_cnt", 32'(end_cnt), 32'd1);

    // Address wrap at 0xFFFE.
    do_reset();
    start_xfer(1'b0, 16'hFFFE, 16'd2);
    wait_end("wrap_end_seen", 30);
    drop_rqst();
    check("wrap_addr0", q_addr(0), 32'h7FFF);
    check("wrap_addr1", q_addr(1), 32'h0000);

    // Bus error on word 2 of 4.
    do_reset();
    wr_vals[0] = 16'h0001; wr_vals[1] = 16'h0002; wr_vals[2] = 16'h0003; wr_vals[3] = 16'h0004;
    err_idx = 2;
    start_xfer(1'b0, 16'h0100, 16'd4);
    wait_end("err_end_seen", 40);
    drop_rqst();
    check("err_n_acc", 32'(acc_addr.size()), 32'd2);
    check("err_n_ack", 32'(ack_data.size()), 32'd1);
    check("err_err_cnt", 32'(err_cnt), 32'd1);
    check("err_end_cnt", 32'(end_cnt), 32'd1);
    check("err_same_cycle", 32'(end_cyc == err_cyc), 32'd1);
    err_idx = 0;

    // Request dropped while waiting for the device: silent return to IDLE.
    do_reset();
    dev_ack_en = 1'b0;
    start_xfer(1'b0, 16'h0100, 16'd3);
    step(3);
    dma_rqst = 1'b0;
    step(3);
    check("abort_en_cycles", 32'(en_cnt), 32'd0);
    check("abort_flags", 32'(end_cnt + err_cnt), 32'd0);
    check("abort_n_ack", 32'(ack_data.size()), 32'd0);
    dev_ack_en = 1'b1;
    start_xfer(1'b0, 16'h0100, 16'd1);
    wait_end("abort_restart_end", 20);
    drop_rqst();
    check("abort_restart_acc", 32'(acc_addr.size()), 32'd1);

    // Reset asserted mid-access.
    do_reset();
    mem_wait = 50;
    start_xfer(1'b0, 16'h0100, 16'd1);
    n = 0;
    while (!dma_en && n < 20) begin
      step(1);
      n++;
    end
    check("rstmid_en_seen", 32'(dma_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rstmid_en", 32'(dma_en), 32'd0);
    check("rstmid_addr", 32'(dma_addr), 32'd0);
    dma_rqst = 1'b0;
    step(2);
    reset = 1'b0;
    mem_wait = 0;

`ifdef SIMPLE_DMA_TIMEOUT_EN
    // Watchdog: memory never ready, TIMEOUT_CYCLES = 4.
    do_reset();
    mem_wait = 100;
    start_xfer(1'b0, 16'h0100, 16'd1);
    wait_end("to_end_seen", 30);
    drop_rqst();
    check("to_en_cycles", 32'(en_cnt), 32'd4);
    check("to_err_cnt", 32'(err_cnt), 32'd1);
    check("to_same_cycle", 32'(end_cyc == err_cyc), 32'd1);
    check("to_n_ack", 32'(ack_data.size()), 32'd0);
    mem_wait = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/simple_dma_controller.md
Name: simple_dma_controller

Overview:
- DMA engine directly downstream of the simple_dma_device peripheral.
- Consumes the device's request, start address, word count, direction, dev_ack and write data.
- Performs word transfers on the openMSP430 DMA memory port.
- Returns read data, a per-word acknowledge, and end/error flags to the device.

Parameters:
- PRIORITY, 1'b0, constant value driven on dma_priority.
- TIMEOUT_CYCLES, 255, maximum cycles ACCESS may wait for dma_ready; used only with the optional feature; range 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- dma_rqst  in  1  transfer request from device, level
- dma_rd_wr  in  1  1: memory->device read; 0: device->memory write
- dma_start_address  in  16  byte start address; bit0 ignored
- dma_num_words  in  16  words to transfer
- dev_ack  in  1  device ready for next word
- dev_out  in  16  write data from device
- dma_ack  out  1  one-cycle per-word acknowledge
- dev_in  out  16  read data to device
- dma_end_flag  out  1  one-cycle end-of-transfer pulse
- dma_error_flag  out  1  one-cycle error pulse
- dma_addr  out  15  memory word address
- dma_din  out  16  memory write data
- dma_en  out  1  memory access request
- dma_we  out  2  byte write enables
- dma_priority  out  1  bus priority
- dma_dout  in  16  memory read data, valid the cycle after dma_ready
- dma_ready  in  1  access accepted this cycle
- dma_resp  in  1  error response, qualified by dma_ready

Behaviour:
- Reset:
  - All outputs 0, except dma_priority = PRIORITY.
  - State IDLE; internal addr, count and wdata cleared.
  - Applies immediately, including mid-access.
- States: IDLE, WAIT_DEV, ACCESS, CAPTURE, ACK, DONE.
- IDLE, when dma_rqst=1:
  - Latch addr = dma_start_address & 16'hFFFE, cnt = dma_num_words, dir = dma_rd_wr.
  - If dma_num_words==0, go to DONE (no memory access). Otherwise go to WAIT_DEV.
- WAIT_DEV:
  - If dma_rqst=0, go to IDLE (silent abort, no flags).
  - Else if dev_ack=1: for writes, latch wdata = dev_out; go to ACCESS.
- ACCESS:
  - Drive dma_en=1, dma_addr=addr[15:1], dma_din=wdata.
  - dma_we = 2'b11 for writes, 2'b00 for reads.
  - All four are held stable until dma_ready=1.
  - dma_rqst is ignored in this state; an access in flight always completes.
  - On dma_ready & dma_resp: go to DONE with error.
  - On dma_ready & ~dma_resp: reads go to CAPTURE, writes go to ACK.
- CAPTURE: dev_in <= dma_dout; go to ACK.
- ACK:
  - dma_ack=1 for exactly one cycle; dev_in is stable and valid throughout.
  - addr += 2, wrapping 16'hFFFE -> 16'h0000; cnt -= 1.
  - If the pre-decrement cnt==1, go to DONE. Else if dma_rqst=0, go to IDLE. Else go to WAIT_DEV.
- DONE:
  - First cycle: dma_end_flag=1. In the error case, dma_error_flag=1 in the same cycle.
  - Stay in DONE until dma_rqst=0, then go to IDLE. No retrigger while the request stays high.
- dma_en is 0 in every state except ACCESS.
- Outputs are registered, except dma_en/dma_addr/dma_we/dma_din, which are decoded from state and registers.
- Latency per word:
  - Write: dev_ack seen -> dma_en next cycle; dma_ack 1 cycle after the dma_ready cycle.
  - Read: dma_ack 2 cycles after the dma_ready cycle.
  - With a zero-wait memory and dev_ack held high: 3 cycles/word for writes, 4 cycles/word for reads.

Optional Feature:
- Macro: SIMPLE_DMA_TIMEOUT_EN.
- Defined:
  - Watchdog counts cycles spent in ACCESS without dma_ready.
  - On reaching TIMEOUT_CYCLES: deassert dma_en, go to DONE with dma_error_flag and dma_end_flag pulsed.
  - The counter clears on every entry to ACCESS.
- Undefined: no watchdog; ACCESS waits indefinitely.

Decomposition:
- Package simple_dma_pkg:
  - State encoding constants.
  - WE_WORD = 2'b11, WE_NONE = 2'b00, ADDR_STEP = 16'd2.
- One sub-module, simple_dma_watchdog (timeout counter, TIMEOUT_CYCLES parameter, outputs expire).
  - Instantiated only under SIMPLE_DMA_TIMEOUT_EN.

Test Plan:
- Write 3 words: start 16'h0200, words 3, rd_wr=0, dev_ack=1, dev_out A1/B2/C3, ready always 1 -> writes at dma_addr 15'h0100/0101/0102 with dma_we=11 and matching data; 3 dma_ack pulses; single dma_end_flag.
- Read 2 words: start 16'h0301, memory returns 1234/5678 -> bit0 ignored; dma_addr 15'h0180/0181; dev_in=1234 then 5678, each valid during its dma_ack; dma_end_flag once.
- Non-atomic: dev_ack low 5 cycles between words, ready delayed 2 cycles -> dma_en stays low in WAIT_DEV; address and data stable while dma_en waits; no extra dma_ack.
- Boundaries: words 0 -> dma_end_flag next cycle, dma_en never asserted. Start 16'hFFFE, words 2 -> dma_addr 15'h7FFF then 15'h0000.
- Error and abort:
  - dma_resp=1 on word 2 of 4 -> dma_error_flag and dma_end_flag in the same cycle; only 1 dma_ack.
  - dma_rqst dropped in WAIT_DEV -> IDLE, no flags.
  - Reset mid-ACCESS -> dma_en=0 immediately.
- Timeout (macro on, TIMEOUT_CYCLES=4): ready held 0 -> dma_en drops after 4 cycles; error and end pulses.
